// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_D = 2'd1,
    ST_BUSY_I = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_W = 4;
  localparam logic [31:0] POISON   = 32'hDEADBEEF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// Busy-cycle timeout counter for the arbiter; present only when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module unified_mem_arbiter_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expires on the LIMIT-th enabled cycle since the last clear.
  assign expire_c = enable && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, data first with a
// starvation limit for fetch. Define MEM_ARB_TIMEOUT_EN to add the busy timeout and sticky err.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
`ifdef MEM_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                err_q, err_d;
  logic                grant_c;
  logic                timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
  logic busy_c;
  assign busy_c = (state_q != ST_IDLE);

  unified_mem_arbiter_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (grant_c),
    .enable   (busy_c && !mem_ack),
    .expire_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    grant_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The cycle carrying a done pulse is dead: no grant, so the finishing requester's held req is not re-taken.
        if (!i_done_q && !d_done_q) begin
          if (d_req && (!i_req || (starve_cnt_q < STARVE_W'(STARVE_MAX)))) begin
            state_d     = ST_BUSY_D;
            grant_c     = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (i_req) begin
              starve_cnt_d = sat_inc(starve_cnt_q);
            end
          end else if (i_req) begin
            state_d      = ST_BUSY_I;
            grant_c      = 1'b1;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr;
            starve_cnt_d = '0;
          end
        end
      end
      ST_BUSY_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          state_d   = ST_IDLE;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (timeout_c) begin
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = DATA_W'(POISON);
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY_I: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = ADDR_W'(mem_rdata);
          state_d   = ST_IDLE;
        end else if (timeout_c) begin
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = ADDR_W'(POISON);
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a wait-state memory model.
module tb_unified_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  logic ack_q;
  logic ack_force;
  logic ack_en;
  int   wait_cfg;
  int   wcnt;
  int   n_checks;
  int   n_fail;

  unified_mem_arbiter #(
`ifdef MEM_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES (8),
`endif
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2010FFFF : (a ^ 32'hCAFE0000);
  endfunction

  assign mem_rdata = mem_model(mem_addr);
  assign mem_ack   = ack_q | ack_force;

  // Memory: registered one-cycle ack after wait_cfg wait states.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      wcnt  <= 0;
    end else if (mem_req && !ack_q && ack_en) begin
      if (wcnt >= wait_cfg) begin
        ack_q <= 1'b1;
        wcnt  <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  task automatic test_reset;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %h exp 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %h exp 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
    n_checks++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL rst_i_done: got %h exp 0", i_done); end
    n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL rst_d_done: got %h exp 0", d_done); end
    n_checks++; if (i_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_i_rdata: got %h exp 0", i_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata: got %h exp 0", d_rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %h exp 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    wait_cfg = 0;
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge clock);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL f_mem_req: got %h exp 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL f_mem_addr: got %h exp 40", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL f_mem_we: got %h exp 0", mem_we); end
    n_checks++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL f_stall_busy: got %h exp 1", i_stall); end
    @(negedge clock);
    n_checks++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL f_done_early: got %h exp 0", i_done); end
    @(negedge clock);
    n_checks++; if (i_done !== 1'b1) begin n_fail++; $display("FAIL f_done: got %h exp 1", i_done); end
    n_checks++; if (i_rdata !== 32'h2010FFFF) begin n_fail++; $display("FAIL f_rdata: got %h exp 2010ffff", i_rdata); end
    n_checks++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL f_stall_done: got %h exp 0", i_stall); end
    i_req = 1'b0;
    @(negedge clock);
    n_checks++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL f_done_pulse: got %h exp 0", i_done); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL f_mem_req_off: got %h exp 0", mem_req); end
  endtask

  task automatic test_priority;
    logic exp_st;
    wait_cfg = 3;
    @(negedge clock);
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      exp_st = (k < 13);
      n_checks++; if (i_stall !== exp_st) begin n_fail++; $display("FAIL p_i_stall k=%0d: got %h exp %h", k, i_stall, exp_st); end
      if (k == 1) begin
        n_checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_fail++; $display("FAIL p_data_first: got addr %h we %h exp 100/0", mem_addr, mem_we); end
      end
      if (k == 6) begin
        n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL p_d_done: got %h exp 1", d_done); end
        n_checks++; if (d_rdata !== 32'hCAFE0100) begin n_fail++; $display("FAIL p_d_rdata: got %h exp cafe0100", d_rdata); end
        d_req = 1'b0;
      end
      if (k == 7) begin
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL p_dead_cycle: got %h exp 0", mem_req); end
      end
      if (k == 8) begin
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL p_fetch_grant: got req %h addr %h exp 1/44", mem_req, mem_addr); end
      end
      if (k == 13) begin
        n_checks++; if (i_done !== 1'b1) begin n_fail++; $display("FAIL p_i_done: got %h exp 1", i_done); end
        n_checks++; if (i_rdata !== 32'hCAFE0044) begin n_fail++; $display("FAIL p_i_rdata: got %h exp cafe0044", i_rdata); end
        i_req = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_store;
    int ndone;
    wait_cfg = 0;
    ndone = 0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (d_done === 1'b1) ndone++;
      if (k == 1) begin
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin
          n_fail++; $display("FAIL s_mem: got we %h wdata %h addr %h exp 1/12345678/200", mem_we, mem_wdata, mem_addr);
        end
      end
      if (k == 3) begin
        n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL s_d_done: got %h exp 1", d_done); end
        n_checks++; if (d_rdata !== 32'hCAFE0100) begin n_fail++; $display("FAIL s_d_rdata_kept: got %h exp cafe0100", d_rdata); end
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL s_done_count: got %0d exp 1", ndone); end
  endtask

  task automatic test_starvation;
    logic [9:0] is_fetch;
    int got;
    logic exp_f;
    wait_cfg = 0;
    got = 0;
    is_fetch = '0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    i_req = 1'b1; i_addr = 32'h48;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clock);
      if (d_done === 1'b1 || i_done === 1'b1) begin
        is_fetch[got] = i_done;
        got++;
      end
      if (got == 10) begin
        d_req = 1'b0; i_req = 1'b0;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL st_grants_timeout: got %0d exp 10", got); end
    for (int g = 0; g < 10; g++) begin
      exp_f = (g % 5 == 4);
      n_checks++; if (is_fetch[g] !== exp_f) begin n_fail++; $display("FAIL st_order g=%0d: got fetch=%h exp %h", g, is_fetch[g], exp_f); end
    end
    n_checks++; if (d_rdata !== 32'hCAFE0300) begin n_fail++; $display("FAIL st_d_rdata: got %h exp cafe0300", d_rdata); end
    n_checks++; if (i_rdata !== 32'hCAFE0048) begin n_fail++; $display("FAIL st_i_rdata: got %h exp cafe0048", i_rdata); end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    ack_en = 1'b0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clock);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL rm_busy: got req %h addr %h exp 1/400", mem_req, mem_addr); end
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1; ack_force = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_async_req: got %h exp 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rm_async_regs: got addr %h d %h i %h exp 0", mem_addr, d_rdata, i_rdata);
    end
    d_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; ack_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++; if (mem_req !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0) begin
        n_fail++; $display("FAIL rm_idle_ack k=%0d: got req %h dd %h id %h exp 0", k, mem_req, d_done, i_done);
      end
    end
    ack_force = 1'b0;
    @(negedge clock);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int early;
    early = 0;
    ack_en = 1'b0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k < 9 && d_done === 1'b1) early++;
      if (k == 9) begin
        n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL to_d_done: got %h exp 1", d_done); end
        n_checks++; if (d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_d_rdata: got %h exp deadbeef", d_rdata); end
        n_checks++; if (err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_err: got err %h req %h exp 1/0", err, mem_req); end
        d_req = 1'b0;
      end
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early_done: got %0d exp 0", early); end
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %h exp 1", err); end
    ack_en = 1'b1;
  endtask
`else
  task automatic test_no_timeout;
    int ndone;
    ndone = 0;
    ack_en = 1'b0;
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (d_done === 1'b1) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL nt_done: got %0d exp 0", ndone); end
    n_checks++; if (mem_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL nt_wait: got req %h err %h exp 1/0", mem_req, err); end
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clock);
    reset = 1'b0; ack_en = 1'b1;
    @(negedge clock);
  endtask
`endif

  initial begin
    clock = 1'b0; reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    ack_force = 1'b0; ack_en = 1'b1; wait_cfg = 0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_starvation();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
